radix4_multiplier: RTL
======================

Name: radix4_multiplier

Overview:
- Sequential radix-4 integer multiplier; the multiply-side counterpart to the radix-4 divider in the RV32M execute unit.
- Retires 2 multiplier bits per cycle and produces the full 2×NUM_BITS-bit product.
- Covers MUL/MULH/MULHSU/MULHU through per-operand signedness; the issuing stage selects the low or high half.
- Uses the same start/finished handshake as the divider so both share one M-unit sequencer.

Parameters:
NUM_BITS, 32, operand width; must be even and ≥4

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset, synchronous, active-high
start  input  1  single-cycle pulse; samples operands and begins a multiply
a_signed  input  1  multiplicand treated as two's complement when 1
b_signed  input  1  multiplier treated as two's complement when 1
multiplicand  input  NUM_BITS  operand A, sampled only on start
multiplier  input  NUM_BITS  operand B, sampled only on start
product  output  2*NUM_BITS  A×B; valid while finished=1
finished  output  1  high from completion until the next start or RST

Behaviour:
- Reset (RST=1 at edge): product=0, finished=0, count=0 (idle), internal operand and negate registers=0. RST has priority over start.
- Idle: count==0 and no start. All registers hold; product and finished hold their last values.
- Start edge (start=1, RST=0):
  - mcand_r <= |A| if (a_signed & A[MSB]), else A; mplr_r <= |B| likewise with b_signed.
  - negate_r <= (a_signed & A[MSB]) ^ (b_signed & B[MSB]).
  - product <= 0, count <= NUM_BITS/2, finished <= 0.
  - Operands and signedness need not be held after the start cycle.
- Iterate (count≠0, no start), each edge:
  - d = mplr_r[1:0] selects addend 0, M, 2M or 3M, where M = mcand_r.
  - 2M and 3M are formed combinationally; 3M = (M<<1)+M, NUM_BITS+2 bits wide.
  - Addend is added into the upper NUM_BITS+2 bits of the accumulator. The {acc, low half} pair shifts right by 2.
  - mplr_r shifts right by 2; count decrements by 1.
- Final iteration (count==1):
  - If negate_r, product <= ~sum+1 over the full 2×NUM_BITS bits, else product <= sum.
  - finished <= 1 on the same edge; count becomes 0.
- Latency: finished is high on the NUM_BITS/2-th rising edge after the start edge (16 for NUM_BITS=32). Fixed; no early-out on zero operands.
- Abs of most-negative value (0x80000000) is taken as unsigned 2^(NUM_BITS-1); the result is still exact.
- Arithmetic: the accumulator is NUM_BITS+2 bits so 3M plus the partial sum never overflows. Carries beyond 2×NUM_BITS do not occur for unsigned magnitudes.
- Start while busy: aborts the current operation, reloads from the new operands, and restarts the full latency. finished stays 0.
- Start in the same cycle finished would rise: start wins; finished <= 0, new operation begins.
- Start while finished=1: finished drops on the start edge.
- RST mid-operation: returns to idle with product=0 and finished=0. No spurious finished follows.
- product is never X after reset. It changes only on start (cleared), during iteration, or on RST.

Test Plan:
- Unsigned max: A=B=0xFFFFFFFF, signed flags 0, start pulse -> finished rises exactly 16 cycles later; product=0xFFFFFFFE_00000001.
- Signed×signed: A=0xFFFFFFF9 (-7), B=0x00000003, both flags 1 -> product=0xFFFFFFFF_FFFFFFEB; also A=B=0x80000000 signed -> 0x40000000_00000000.
- Signed×unsigned (MULHSU): A=0xFFFFFFFF with a_signed=1, B=0xFFFFFFFF with b_signed=0 -> product=0xFFFFFFFF_00000001.
- Zero and identity: A=0x12345678, B=0 -> product=0 after 16 cycles; A=0x12345678, B=1 unsigned -> 0x00000000_12345678.
- Restart: start A=3, B=5; 5 cycles later start A=7, B=9 -> finished stays 0 until 16 cycles after the second start; product=0x3F; the value 15 never appears with finished=1.
- Reset: start A=B=0xFFFFFFFF, assert RST for one cycle at iteration 8 -> product=0, finished=0 and both remain 0 for ≥20 cycles; a subsequent start completes normally.

Source files
------------

// File: rtl/radix4_multiplier.sv
// Sequential radix-4 integer multiplier for the RV32M execute unit.
// Retires two multiplier bits per cycle and returns the full 2*NUM_BITS-bit
// product. Operands are reduced to magnitudes at start, multiplied unsigned,
// and the sign is restored on the final iteration. Shares the start/finished
// handshake with the radix-4 divider.
module radix4_multiplier #(
    parameter int NUM_BITS = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic                      a_signed,
    input  logic                      b_signed,
    input  logic [NUM_BITS-1:0]       multiplicand,
    input  logic [NUM_BITS-1:0]       multiplier,
    output logic [2*NUM_BITS-1:0]     product,
    output logic                      finished
);

    localparam int ACC_W = NUM_BITS + 2;
    localparam int PROD_W = 2 * NUM_BITS;
    localparam int CNT_W = $clog2(NUM_BITS / 2 + 1);
    localparam logic [CNT_W-1:0] ITERS = CNT_W'(NUM_BITS / 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PROD_W-1:0] PROD_ONE = PROD_W'(1);
    localparam logic [NUM_BITS-1:0] OP_ONE = NUM_BITS'(1);

    // Two's-complement magnitude; the most-negative value maps onto the
    // unsigned 2^(NUM_BITS-1), which is exactly what the unsigned core needs.
    function automatic logic [NUM_BITS-1:0] magnitude(
        input logic [NUM_BITS-1:0] value,
        input logic                is_neg
    );
        logic [NUM_BITS-1:0] result;
        if (is_neg) begin
            result = ~value + OP_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // The low half of the running product shifts into the top of mplr_r as
    // multiplier digits are consumed, so {acc_r, mplr_r} is one shift pair.
    logic [NUM_BITS-1:0] mcand_r;
    logic [NUM_BITS-1:0] mplr_r;
    logic [ACC_W-1:0]    acc_r;
    logic                negate_r;
    logic [CNT_W-1:0]    count_r;
    logic [PROD_W-1:0]   product_r;
    logic                finished_r;

    logic                a_neg_s;
    logic                b_neg_s;
    logic [ACC_W-1:0]    m1_s;
    logic [ACC_W-1:0]    m2_s;
    logic [ACC_W-1:0]    m3_s;
    logic [ACC_W-1:0]    addend_s;
    logic [ACC_W-1:0]    hi_sum_s;
    logic [ACC_W-1:0]    acc_next_s;
    logic [NUM_BITS-1:0] mplr_next_s;
    logic [PROD_W-1:0]   sum_s;
    logic [PROD_W-1:0]   result_s;

    assign a_neg_s = a_signed & multiplicand[NUM_BITS-1];
    assign b_neg_s = b_signed & multiplier[NUM_BITS-1];

    // Form the multiples of M and pick the addend for the current digit.
    always_comb begin
        m1_s = {2'b00, mcand_r};
        m2_s = {1'b0, mcand_r, 1'b0};
        m3_s = m2_s + m1_s;
        addend_s = {ACC_W{1'b0}};
        case (mplr_r[1:0])
            2'b00:   addend_s = {ACC_W{1'b0}};
            2'b01:   addend_s = m1_s;
            2'b10:   addend_s = m2_s;
            2'b11:   addend_s = m3_s;
            default: addend_s = {ACC_W{1'b0}};
        endcase
    end

    // Accumulate, shift the pair right by two, and form the signed result.
    always_comb begin
        hi_sum_s    = acc_r + addend_s;
        acc_next_s  = {2'b00, hi_sum_s[ACC_W-1:2]};
        mplr_next_s = {hi_sum_s[1:0], mplr_r[NUM_BITS-1:2]};
        sum_s       = {hi_sum_s, mplr_r[NUM_BITS-1:2]};
        if (negate_r) begin
            result_s = ~sum_s + PROD_ONE;
        end else begin
            result_s = sum_s;
        end
    end

    // Operand load, iteration and completion; reset wins over start, start
    // wins over iteration (including the cycle finished would have risen).
    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand_r    <= {NUM_BITS{1'b0}};
            mplr_r     <= {NUM_BITS{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            negate_r   <= 1'b0;
            count_r    <= CNT_ZERO;
            product_r  <= {PROD_W{1'b0}};
            finished_r <= 1'b0;
        end else if (start) begin
            mcand_r    <= magnitude(multiplicand, a_neg_s);
            mplr_r     <= magnitude(multiplier, b_neg_s);
            acc_r      <= {ACC_W{1'b0}};
            negate_r   <= a_neg_s ^ b_neg_s;
            count_r    <= ITERS;
            product_r  <= {PROD_W{1'b0}};
            finished_r <= 1'b0;
        end else if (count_r != CNT_ZERO) begin
            acc_r   <= acc_next_s;
            mplr_r  <= mplr_next_s;
            count_r <= count_r - CNT_ONE;
            if (count_r == CNT_ONE) begin
                product_r  <= result_s;
                finished_r <= 1'b1;
            end else begin
                product_r  <= product_r;
                finished_r <= finished_r;
            end
        end else begin
            count_r    <= count_r;
            product_r  <= product_r;
            finished_r <= finished_r;
        end
    end

    assign product  = product_r;
    assign finished = finished_r;

endmodule
